// File: rtl/lsu_if.sv
// Core-side request/response bundle of the load/store unit.
// master: the core that issues accesses; slave: the load/store unit.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time between the core and a word-wide
// data memory. Sub-word stores use read-modify-write; loads are lane
// selected and sign/zero extended.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned
// half/word accesses with rsp_err; otherwise they are truncated to
// natural alignment.
module load_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   lsu_if.slave        bus,
   output logic        o_mem_read,
   output logic        o_mem_write,
   output logic [5:0]  o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_LD, S_RMW_RD, S_ST_WR, S_RESP} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   state_t      r_state, w_next;
   logic        r_we, r_unsigned, r_err;
   logic [1:0]  r_size;
   logic [7:0]  r_addr;
   logic [31:0] r_wdata, r_rdata;

   logic        w_accept, w_req_err;
   logic [1:0]  w_lane;
   logic [31:0] w_merged, w_shifted, w_load;

   assign w_accept = bus.req_valid && (r_state == S_IDLE);

   // Classify the incoming request as rejected before any memory access
   always_comb begin
      w_req_err = (bus.req_size == SZ_ILL);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((bus.req_size == SZ_HALF) && bus.req_addr[0])
         w_req_err = 1'b1;
      if ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
         w_req_err = 1'b1;
`endif
   end

   // Effective lane: misaligned half/word addresses fall back to natural alignment
   always_comb begin
      case (r_size)
         SZ_HALF: w_lane = {r_addr[1], 1'b0};
         SZ_WORD: w_lane = 2'b00;
         default: w_lane = r_addr[1:0];
      endcase
   end

   // Store merge: replace the addressed lane(s) of the read-back base word
   always_comb begin
      // NOTE: default assigned first so every path drives the signal and no latch is inferred.
      w_merged = r_rdata;
      case (r_size)
         SZ_BYTE: w_merged[{w_lane, 3'b000} +: 8]  = r_wdata[7:0];
         SZ_HALF: w_merged[{w_lane, 3'b000} +: 16] = r_wdata[15:0];
         default: w_merged = r_wdata;
      endcase
   end

   // Load extraction: shift the lane down, then extend per the latched unsigned bit
   always_comb begin
      w_shifted = r_rdata >> {w_lane, 3'b000};
      case (r_size)
         SZ_BYTE: w_load = r_unsigned ? {24'h0, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
         SZ_HALF: w_load = r_unsigned ? {16'h0, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: w_load = r_rdata;
      endcase
   end

   // State register; reset forces IDLE immediately, abandoning any access
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Request capture on accept and memory read data capture in LD/RMW_RD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we       <= 1'b0;
         r_size     <= SZ_BYTE;
         r_unsigned <= 1'b0;
         r_addr     <= 8'h00;
         r_wdata    <= 32'h0;
         r_err      <= 1'b0;
         r_rdata    <= 32'h0;
      end else begin
         if (w_accept) begin
            r_we       <= bus.req_we;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
            r_err      <= w_req_err;
         end
         if ((r_state == S_LD) || (r_state == S_RMW_RD))
            r_rdata <= i_mem_rdata;
      end
   end

   // Next-state and Moore outputs; everything idles at 0 outside its owning state
   always_comb begin
      w_next        = r_state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = 32'h0;
      bus.rsp_err   = 1'b0;
      o_mem_read    = 1'b0;
      o_mem_write   = 1'b0;
      o_mem_addr    = 6'h00;
      o_mem_wdata   = 32'h0;
      case (r_state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (w_req_err)                  w_next = S_RESP;
               else if (!bus.req_we)           w_next = S_LD;
               else if (bus.req_size == SZ_WORD) w_next = S_ST_WR;
               else                            w_next = S_RMW_RD;
            end
         end
         S_LD: begin
            o_mem_read = 1'b1;
            o_mem_addr = r_addr[7:2];
            w_next     = S_RESP;
         end
         S_RMW_RD: begin
            o_mem_read = 1'b1;
            o_mem_addr = r_addr[7:2];
            w_next     = S_ST_WR;
         end
         S_ST_WR: begin
            o_mem_write = 1'b1;
            o_mem_addr  = r_addr[7:2];
            o_mem_wdata = w_merged;
            w_next      = S_RESP;
         end
         S_RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = r_err;
            bus.rsp_rdata = (r_we || r_err) ? 32'h0 : w_load;
            w_next        = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// 64-word data memory (combinational read, write on rising edge).
`timescale 1ns/1ps
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read, mem_write;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [31:0] mem [64];

   int n_checks = 0;
   int n_fail   = 0;

   lsu_if bus ();

   load_store_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .o_mem_read  (mem_read),
      .o_mem_write (mem_write),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge; it is accepted on the next rising
   // edge (end of cycle T). Returns right after that edge.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [7:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      chk("ready_before_issue", {31'h0, bus.req_ready}, 32'h1);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   // Word store, two-cycle latency; checks the write strobe and the response.
   task automatic store_word(input string tag, input logic [7:0] addr, input logic [31:0] data);
      issue(1'b1, 2'b10, 1'b0, addr, data);
      @(negedge clk); // T+1
      chk({tag, "_wr"},    {31'h0, mem_write}, 32'h1);
      chk({tag, "_wdata"}, mem_wdata, data);
      chk({tag, "_waddr"}, {26'h0, mem_addr}, {26'h0, addr[7:2]});
      @(negedge clk); // T+2
      chk({tag, "_rsp"},   {31'h0, bus.rsp_valid}, 32'h1);
      chk({tag, "_err"},   {31'h0, bus.rsp_err}, 32'h0);
   endtask

   // Load with two-cycle latency; checks the read strobe and the result.
   task automatic load(input string tag, input logic [1:0] size, input logic uns,
                       input logic [7:0] addr, input logic [5:0] exp_waddr,
                       input logic [31:0] exp_data);
      issue(1'b0, size, uns, addr, 32'h0);
      @(negedge clk); // T+1
      chk({tag, "_rd"},    {31'h0, mem_read}, 32'h1);
      chk({tag, "_raddr"}, {26'h0, mem_addr}, {26'h0, exp_waddr});
      chk({tag, "_norsp"}, {31'h0, bus.rsp_valid}, 32'h0);
      @(negedge clk); // T+2
      chk({tag, "_rsp"},   {31'h0, bus.rsp_valid}, 32'h1);
      chk({tag, "_data"},  bus.rsp_rdata, exp_data);
      chk({tag, "_err"},   {31'h0, bus.rsp_err}, 32'h0);
   endtask

   // Sub-word store: read at T+1, merged write at T+2, response at T+3.
   task automatic store_sub(input string tag, input logic [1:0] size, input logic [7:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_word);
      issue(1'b1, size, 1'b0, addr, wdata);
      @(negedge clk); // T+1
      chk({tag, "_rd"},    {31'h0, mem_read}, 32'h1);
      chk({tag, "_nowr"},  {31'h0, mem_write}, 32'h0);
      @(negedge clk); // T+2
      chk({tag, "_wr"},    {31'h0, mem_write}, 32'h1);
      chk({tag, "_nord"},  {31'h0, mem_read}, 32'h0);
      chk({tag, "_wdata"}, mem_wdata, exp_word);
      chk({tag, "_waddr"}, {26'h0, mem_addr}, {26'h0, addr[7:2]});
      @(negedge clk); // T+3
      chk({tag, "_rsp"},   {31'h0, bus.rsp_valid}, 32'h1);
      chk({tag, "_rdata0"}, bus.rsp_rdata, 32'h0);
      chk({tag, "_mem"},   mem[addr[7:2]], exp_word);
   endtask

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 8'h00;
      bus.req_wdata    = 32'h0;

      // Reset state
      #2;
      chk("rst_ready",     {31'h0, bus.req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      chk("rst_rsp_err",   {31'h0, bus.rsp_err}, 32'h0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_mem_read",  {31'h0, mem_read}, 32'h0);
      chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
      chk("rst_mem_addr",  {26'h0, mem_addr}, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Preload through word stores
      store_word("pre_w2", 8'h08, 32'hAA22CC33);
      store_word("pre_w3", 8'h0C, 32'h11223344);
      store_word("pre_w1", 8'h04, 32'h8765F00D);

      // Byte loads from the top lane, signed then unsigned
      load("lb_s", 2'b00, 1'b0, 8'h0B, 6'd2, 32'hFFFFFFAA);
      @(negedge clk); // T+3: back in IDLE, response cleared
      chk("lb_s_idle_ready", {31'h0, bus.req_ready}, 32'h1);
      chk("lb_s_idle_rsp",   {31'h0, bus.rsp_valid}, 32'h0);
      chk("lb_s_idle_rdata", bus.rsp_rdata, 32'h0);
      load("lb_u", 2'b00, 1'b1, 8'h0B, 6'd2, 32'h000000AA);

      // Byte store via read-modify-write into lane 1
      store_sub("sb", 2'b00, 8'h09, 32'hFFFFFF5C, 32'hAA225C33);

      // Half store into lane 2 of word 3
      store_sub("sh", 2'b01, 8'h0E, 32'hFFFF1234, 32'h12343344);

      // Word store then upper half load unsigned
      store_word("sw", 8'h10, 32'hDEADBEEF);
      load("lh_u", 2'b01, 1'b1, 8'h12, 6'd4, 32'h0000DEAD);
      load("lb0_s", 2'b00, 1'b0, 8'h10, 6'd4, 32'hFFFFFFEF);
      load("lw", 2'b10, 1'b1, 8'h10, 6'd4, 32'hDEADBEEF);

      // Misaligned half load at 0x05
`ifdef LSU_MISALIGN_TRAP_EN
      issue(1'b0, 2'b01, 1'b0, 8'h05, 32'h0);
      @(negedge clk); // T+1
      chk("mis_rsp",   {31'h0, bus.rsp_valid}, 32'h1);
      chk("mis_err",   {31'h0, bus.rsp_err}, 32'h1);
      chk("mis_rdata", bus.rsp_rdata, 32'h0);
      chk("mis_nord",  {31'h0, mem_read}, 32'h0);
`else
      load("mis_lh", 2'b01, 1'b0, 8'h05, 6'd1, 32'hFFFFF00D);
`endif

      // Illegal size on a store: error at T+1, no memory access
      issue(1'b1, 2'b11, 1'b0, 8'h0C, 32'h55555555);
      @(negedge clk); // T+1
      chk("ill_rsp",   {31'h0, bus.rsp_valid}, 32'h1);
      chk("ill_err",   {31'h0, bus.rsp_err}, 32'h1);
      chk("ill_rdata", bus.rsp_rdata, 32'h0);
      chk("ill_nowr",  {31'h0, mem_write}, 32'h0);
      chk("ill_nord",  {31'h0, mem_read}, 32'h0);
      @(negedge clk);
      chk("ill_idle_err", {31'h0, bus.rsp_err}, 32'h0);
      chk("ill_mem3",  mem[3], 32'h12343344);

      // Reset pulse during the write cycle of a word store to word 3
      issue(1'b1, 2'b10, 1'b0, 8'h0C, 32'hCAFEF00D);
      @(negedge clk); // T+1
      chk("rstwr_wr", {31'h0, mem_write}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rstwr_drop",  {31'h0, mem_write}, 32'h0);
      chk("rstwr_ready", {31'h0, bus.req_ready}, 32'h1);
      chk("rstwr_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rstwr_mem3",  mem[3], 32'h12343344);
      chk("rstwr_norsp", {31'h0, bus.rsp_valid}, 32'h0);
      @(negedge clk);
      chk("rstwr_norsp2", {31'h0, bus.rsp_valid}, 32'h0);
      chk("rstwr_ready2", {31'h0, bus.req_ready}, 32'h1);

      // Unit still works after the abandoned store
      load("post_lw3", 2'b10, 1'b0, 8'h0C, 6'd3, 32'h12343344);

      @(negedge clk);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
